// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer: prescaler plus down-counter, one-shot/periodic, register-mapped.
// Optional TIMER_OVF_CNT_EN adds an 8-bit saturating overrun counter shown in STATUS[15:8].
module interval_timer_ctrl #(
  parameter int WIDTH  = 32,
  parameter int PWIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [1:0]       addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             irq,
  output logic             busy
);

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_LOAD   = 2'd1;
  localparam logic [1:0] ADDR_PRESC  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_reg, state_next;
  logic              en_reg, en_next;
  logic              periodic_reg, periodic_next;
  logic              irq_en_reg, irq_en_next;
  logic [WIDTH-1:0]  load_reg, load_next;
  logic [WIDTH-1:0]  count_reg, count_next;
  logic [PWIDTH-1:0] presc_reg, presc_next;
  logic [PWIDTH-1:0] presc_cnt_reg, presc_cnt_next;
  logic              irq_pend_reg, irq_pend_next;
  logic [WIDTH-1:0]  rd_data_reg, rd_data_next;
  logic              rd_valid_reg;
  logic [WIDTH-1:0]  status_word;

  logic wr_ctrl, wr_load, wr_presc, wr_status, w1c, tick, expiry;

  assign wr_ctrl   = wr_en && (addr == ADDR_CTRL);
  assign wr_load   = wr_en && (addr == ADDR_LOAD);
  assign wr_presc  = wr_en && (addr == ADDR_PRESC);
  assign wr_status = wr_en && (addr == ADDR_STATUS);
  assign w1c       = wr_status && wr_data[0];
  assign tick      = (presc_cnt_reg == '0);
  // A CTRL write in the same cycle pre-empts counting, so it also pre-empts expiry.
  assign expiry    = (state_reg == RUN) && !wr_ctrl && tick && (count_reg == '0);

`ifdef TIMER_OVF_CNT_EN
  logic [7:0] ovf_cnt_reg, ovf_cnt_next;

  always_comb begin
    ovf_cnt_next = ovf_cnt_reg;
    if (expiry && irq_pend_reg && (ovf_cnt_reg != 8'hFF))
      ovf_cnt_next = ovf_cnt_reg + 8'd1;
    if (w1c)
      ovf_cnt_next = 8'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_cnt_reg <= 8'd0;
    else     ovf_cnt_reg <= ovf_cnt_next;
  end
`endif

  always_comb begin
    status_word = {count_reg[WIDTH-1:1], irq_pend_reg};
`ifdef TIMER_OVF_CNT_EN
    status_word[15:8] = ovf_cnt_reg;
`endif
  end

  // Next-state and datapath update
  always_comb begin
    state_next     = state_reg;
    en_next        = en_reg;
    periodic_next  = periodic_reg;
    irq_en_next    = irq_en_reg;
    load_next      = load_reg;
    presc_next     = presc_reg;
    count_next     = count_reg;
    presc_cnt_next = presc_cnt_reg;
    irq_pend_next  = irq_pend_reg;

    if (wr_load)  load_next  = wr_data;
    if (wr_presc) presc_next = wr_data[PWIDTH-1:0];

    if (wr_ctrl) begin
      en_next       = wr_data[0];
      periodic_next = wr_data[1];
      irq_en_next   = wr_data[2];
      if (wr_data[0]) begin
        state_next     = RUN;
        count_next     = load_reg;
        presc_cnt_next = presc_reg;
      end else if (state_reg == RUN) begin
        state_next = IDLE;
      end
    end else if (state_reg == RUN) begin
      if (tick) begin
        presc_cnt_next = presc_reg;
        if (count_reg != '0) begin
          count_next = count_reg - WIDTH'(1);
        end else if (periodic_reg) begin
          count_next = load_reg;
        end else begin
          state_next = DONE;
          en_next    = 1'b0;
        end
      end else begin
        presc_cnt_next = presc_cnt_reg - PWIDTH'(1);
      end
    end

    // Set has priority over the W1C clear.
    if (w1c)    irq_pend_next = 1'b0;
    if (expiry) irq_pend_next = 1'b1;
  end

  // Read mux samples pre-write register values.
  always_comb begin
    rd_data_next = '0;
    if (rd_en) begin
      case (addr)
        ADDR_CTRL:   rd_data_next = {{(WIDTH-3){1'b0}}, irq_en_reg, periodic_reg, en_reg};
        ADDR_LOAD:   rd_data_next = load_reg;
        ADDR_PRESC:  rd_data_next = {{(WIDTH-PWIDTH){1'b0}}, presc_reg};
        default:     rd_data_next = status_word;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      en_reg        <= 1'b0;
      periodic_reg  <= 1'b0;
      irq_en_reg    <= 1'b0;
      load_reg      <= '0;
      presc_reg     <= '0;
      count_reg     <= '0;
      presc_cnt_reg <= '0;
      irq_pend_reg  <= 1'b0;
      rd_data_reg   <= '0;
      rd_valid_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      en_reg        <= en_next;
      periodic_reg  <= periodic_next;
      irq_en_reg    <= irq_en_next;
      load_reg      <= load_next;
      presc_reg     <= presc_next;
      count_reg     <= count_next;
      presc_cnt_reg <= presc_cnt_next;
      irq_pend_reg  <= irq_pend_next;
      rd_data_reg   <= rd_data_next;
      rd_valid_reg  <= rd_en;
    end
  end

  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;
  assign irq      = irq_pend_reg & irq_en_reg;
  assign busy     = (state_reg == RUN);

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Scoreboard bench for interval_timer_ctrl: reads push expected data, a monitor checks on rd_valid.
module tb_interval_timer_ctrl;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_LOAD   = 2'd1;
  localparam logic [1:0] A_PRESC  = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        irq;
  logic        busy;

  int tests_run = 0;
  int failed    = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [31:0] mon_exp;
  string       mon_name;

  interval_timer_ctrl #(.WIDTH(32), .PWIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .addr     (addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .irq      (irq),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end else begin
      $display("[TB] ok %s = 0x%0h", name, act);
    end
  endtask

  task automatic cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wr_data = d;
    cycle(1);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    exp_q.push_back(exp);
    name_q.push_back(name);
    rd_en = 1'b1; addr = a;
    cycle(1);
    rd_en = 1'b0;
  endtask

  task automatic rdwr(input logic [1:0] a, input logic [31:0] d, input logic [31:0] exp, input string name);
    exp_q.push_back(exp);
    name_q.push_back(name);
    rd_en = 1'b1; wr_en = 1'b1; addr = a; wr_data = d;
    cycle(1);
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  // Monitor: every rd_valid pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        failed++;
        $display("FAIL unexpected_rd_valid: got rd_data 0x%08h required no read", rd_data);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        check(mon_name, rd_data, mon_exp);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset
    rst = 1'b1;
    cycle(2);
    rst = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("reset_rd_data", rd_data, 32'd0);
    rd(A_CTRL, 32'd0, "reset_ctrl");
    rd(A_STATUS, 32'd0, "reset_status");

    // LOAD=0, PRESC=0 one-shot: expiry on the first clock
    wr(A_LOAD, 32'd0);
    wr(A_PRESC, 32'd0);
    wr(A_CTRL, 32'd5);
    check("l0_busy_after_start", {31'd0, busy}, 32'd1);
    check("l0_irq_after_start", {31'd0, irq}, 32'd0);
    cycle(1);
    check("l0_irq_first_clock", {31'd0, irq}, 32'd1);
    check("l0_busy_done", {31'd0, busy}, 32'd0);
    wr(A_STATUS, 32'd1);
    check("w1c_clears_irq", {31'd0, irq}, 32'd0);

    // One-shot LOAD=5: irq exactly 6 clocks after CTRL write
    wr(A_LOAD, 32'd5);
    wr(A_CTRL, 32'd5);
    cycle(5);
    check("oneshot_irq_at_5", {31'd0, irq}, 32'd0);
    check("oneshot_busy_at_5", {31'd0, busy}, 32'd1);
    cycle(1);
    check("oneshot_irq_at_6", {31'd0, irq}, 32'd1);
    check("oneshot_busy_done", {31'd0, busy}, 32'd0);
    rd(A_CTRL, 32'd4, "oneshot_ctrl");
    rd(A_STATUS, 32'd1, "oneshot_status");
    rdwr(A_LOAD, 32'd7, 32'd5, "rdwr_pre_write");
    rd(A_LOAD, 32'd7, "load_after_write");

    // Periodic LOAD=3, PRESC=2: expiry every 12 clocks
    wr(A_STATUS, 32'd1);
    wr(A_LOAD, 32'd3);
    wr(A_PRESC, 32'd2);
    rd(A_PRESC, 32'd2, "presc_read");
    wr(A_CTRL, 32'd7);
    cycle(11);
    check("per_irq_at_11", {31'd0, irq}, 32'd0);
    cycle(1);
    check("per_irq_at_12", {31'd0, irq}, 32'd1);
    check("per_busy", {31'd0, busy}, 32'd1);
    wr(A_STATUS, 32'd1);
    check("per_w1c_clear", {31'd0, irq}, 32'd0);
    cycle(10);
    check("per_irq_at_23", {31'd0, irq}, 32'd0);
    cycle(1);
    check("per_irq_at_24", {31'd0, irq}, 32'd1);
    // W1C landing exactly on the expiry edge at 36
    cycle(11);
    wr(A_STATUS, 32'd1);
    check("collision_irq_kept", {31'd0, irq}, 32'd1);
    rd(A_STATUS, 32'd3, "collision_status");
    wr(A_STATUS, 32'd2);
    check("status_bit1_ignored", {31'd0, irq}, 32'd1);

    // Pause / resume with live reload
    wr(A_CTRL, 32'd0);
    check("stop_busy", {31'd0, busy}, 32'd0);
    wr(A_STATUS, 32'd1);
    wr(A_PRESC, 32'd0);
    wr(A_LOAD, 32'd10);
    wr(A_CTRL, 32'd1);
    cycle(4);
    wr(A_CTRL, 32'd0);
    check("pause_busy", {31'd0, busy}, 32'd0);
    rd(A_STATUS, 32'd6, "pause_count");
    cycle(3);
    rd(A_STATUS, 32'd6, "pause_hold");
    wr(A_LOAD, 32'd2);
    wr(A_CTRL, 32'd3);
    cycle(2);
    rd(A_STATUS, 32'd0, "resume_before_expiry");
    rd(A_STATUS, 32'd3, "resume_after_expiry");
    check("irq_masked", {31'd0, irq}, 32'd0);
    wr(A_CTRL, 32'd7);
    check("irq_unmasked", {31'd0, irq}, 32'd1);

    // Continuous expiry with no clears: overrun counter saturates when present
    wr(A_CTRL, 32'd0);
    wr(A_STATUS, 32'd1);
    wr(A_LOAD, 32'd0);
    wr(A_CTRL, 32'd7);
    cycle(300);
`ifdef TIMER_OVF_CNT_EN
    rd(A_STATUS, 32'h0000_FF01, "ovf_saturated");
`else
    rd(A_STATUS, 32'h0000_0001, "ovf_absent_status");
`endif
    wr(A_STATUS, 32'd1);
    rd(A_STATUS, 32'h0000_0001, "ovf_after_w1c");

    // Reset mid-run
    wr(A_LOAD, 32'd50);
    wr(A_CTRL, 32'd7);
    cycle(5);
    rst = 1'b1;
    cycle(2);
    rst = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_irq", {31'd0, irq}, 32'd0);
    check("midrst_rd_data", rd_data, 32'd0);
    rd(A_STATUS, 32'd0, "midrst_status");
    rd(A_LOAD, 32'd0, "midrst_load");
    rd(A_CTRL, 32'd0, "midrst_ctrl");

    cycle(3);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
